// File: rtl/qspi_cmd_sequencer.sv
// QSPI command sequencer: resolves host flash commands into transfer descriptors,
// inserting Write Enable where needed and tracking WEL / 4-byte address mode.
module qspi_cmd_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int DEPTH     = 4,
    parameter int AUTO_WREN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        flash_type_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [4:0]        cmd_id_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    output logic              desc_valid_o,
    input  logic              desc_ready_i,
    output logic [7:0]        desc_opcode_o,
    output logic [ADDR_W-1:0] desc_addr_o,
    output logic [2:0]        desc_addr_bytes_o,
    output logic [1:0]        desc_addr_lanes_o,
    output logic [4:0]        desc_dummy_o,
    output logic [1:0]        desc_data_lanes_o,
    output logic [1:0]        desc_dir_o,
    output logic [LEN_W-1:0]  desc_len_o,
    output logic              addr4_mode_o,
    output logic              wel_o,
    output logic              err_o
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DECODE    = 2'd1;
    localparam logic [1:0] PUSH_WREN = 2'd2;
    localparam logic [1:0] PUSH_MAIN = 2'd3;

    typedef struct packed {
        logic [7:0]        opcode;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        addr_bytes;
        logic [1:0]        addr_lanes;
        logic [4:0]        dummy;
        logic [1:0]        data_lanes;
        logic [1:0]        dir;
        logic [LEN_W-1:0]  len;
    } desc_t;

    logic [1:0]        state;
    logic [4:0]        id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [1:0]        type_q;
    logic              wel, addr4, err_q;

    desc_t             mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;

    desc_t main_d, wren_d, push_d, head;
    logic  illegal, wr_cmd, push, pop;

    assign illegal = (id_q > 5'd18) || (type_q == 2'b11);
    assign wr_cmd  = (id_q >= 5'd6 && id_q <= 5'd10) || (id_q == 5'd12);

    always_comb begin
        main_d = '0;
        unique case (id_q)
            5'd0:  main_d.opcode = 8'h03;
            5'd1:  main_d.opcode = 8'h0B;
            5'd2:  main_d.opcode = 8'h3B;
            5'd3:  main_d.opcode = 8'h6B;
            5'd4:  main_d.opcode = 8'hBB;
            5'd5:  main_d.opcode = 8'hEB;
            5'd6:  main_d.opcode = 8'h02;
            5'd7:  main_d.opcode = (type_q == 2'b00) ? 8'h38 : 8'h32;
            5'd8:  main_d.opcode = 8'h20;
            5'd9:  main_d.opcode = 8'hD8;
            5'd10: main_d.opcode = (type_q == 2'b10) ? 8'h60 : 8'hC7;
            5'd11: main_d.opcode = 8'h05;
            5'd12: main_d.opcode = 8'h01;
            5'd13: main_d.opcode = 8'h06;
            5'd14: main_d.opcode = 8'h9F;
            5'd15: main_d.opcode = 8'h66;
            5'd16: main_d.opcode = 8'h99;
            5'd17: main_d.opcode = 8'hB7;
            5'd18: main_d.opcode = 8'hE9;
            default: main_d.opcode = 8'h00;
        endcase
        unique case (id_q)
            5'd1, 5'd2, 5'd3: main_d.dummy = 5'd8;
            5'd4:             main_d.dummy = 5'd4;
            5'd5:             main_d.dummy = (type_q == 2'b00) ? 5'd10 : 5'd6;
            default:          main_d.dummy = 5'd0;
        endcase
        if (id_q <= 5'd9) begin
            main_d.addr       = addr_q;
            main_d.addr_bytes = addr4 ? 3'd4 : 3'd3;
        end
        main_d.addr_lanes = (id_q == 5'd4) ? 2'd1 : (id_q == 5'd5) ? 2'd2 : 2'd0;
        unique case (id_q)
            5'd2, 5'd4:       main_d.data_lanes = 2'd1;
            5'd3, 5'd5, 5'd7: main_d.data_lanes = 2'd2;
            default:          main_d.data_lanes = 2'd0;
        endcase
        if (id_q <= 5'd5 || id_q == 5'd11 || id_q == 5'd14)
            main_d.dir = 2'b01;
        else if (id_q == 5'd6 || id_q == 5'd7 || id_q == 5'd12)
            main_d.dir = 2'b10;
        main_d.len = (main_d.dir == 2'b00) ? '0 : len_q;
    end

    always_comb begin
        wren_d        = '0;
        wren_d.opcode = 8'h06;
    end

    assign push         = (state == PUSH_WREN) || (state == PUSH_MAIN);
    assign push_d       = (state == PUSH_WREN) ? wren_d : main_d;
    assign desc_valid_o = (count != '0);
    assign pop          = desc_valid_o && desc_ready_i;
    // Two free slots guarantee room for a WREN plus its command once accepted.
    assign cmd_ready_o  = reset && (state == IDLE) && (count <= (PW+1)'(DEPTH - 2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            id_q   <= '0;
            addr_q <= '0;
            len_q  <= '0;
            type_q <= '0;
            wel    <= 1'b0;
            addr4  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= (state == DECODE) && illegal;
            unique case (state)
                IDLE: if (cmd_valid_i && cmd_ready_o) begin
                    id_q   <= cmd_id_i;
                    addr_q <= cmd_addr_i;
                    len_q  <= cmd_len_i;
                    type_q <= flash_type_i;
                    state  <= DECODE;
                end
                DECODE: begin
                    if (illegal)                                state <= IDLE;
                    else if ((AUTO_WREN != 0) && wr_cmd && !wel) state <= PUSH_WREN;
                    else                                        state <= PUSH_MAIN;
                end
                PUSH_WREN: begin
                    wel   <= 1'b1;
                    state <= PUSH_MAIN;
                end
                default: begin
                    if (id_q == 5'd13) wel <= 1'b1;
                    if (wr_cmd)        wel <= 1'b0;
                    if (id_q == 5'd17) addr4 <= 1'b1;
                    if (id_q == 5'd18) addr4 <= 1'b0;
                    if (id_q == 5'd16) begin
                        addr4 <= 1'b0;
                        wel   <= 1'b0;
                    end
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head              = desc_valid_o ? mem[rd_ptr] : '0;
    assign desc_opcode_o     = head.opcode;
    assign desc_addr_o       = head.addr;
    assign desc_addr_bytes_o = head.addr_bytes;
    assign desc_addr_lanes_o = head.addr_lanes;
    assign desc_dummy_o      = head.dummy;
    assign desc_data_lanes_o = head.data_lanes;
    assign desc_dir_o        = head.dir;
    assign desc_len_o        = head.len;
    assign addr4_mode_o      = addr4;
    assign wel_o             = wel;
    assign err_o             = err_q;
endmodule

// File: tb/tb_qspi_cmd_sequencer.sv
// Scoreboard bench for qspi_cmd_sequencer: directed requests push expected
// descriptors, a negedge monitor pops and compares on every head handshake.
module tb_qspi_cmd_sequencer;
    typedef struct packed {
        logic [7:0]  opcode;
        logic [31:0] addr;
        logic [2:0]  addr_bytes;
        logic [1:0]  addr_lanes;
        logic [4:0]  dummy;
        logic [1:0]  data_lanes;
        logic [1:0]  dir;
        logic [15:0] len;
    } desc_t;

    logic        clk = 0;
    logic        reset = 0;
    logic [1:0]  flash_type = 0;
    logic        cmd_valid = 0;
    logic        cmd_ready;
    logic [4:0]  cmd_id = 0;
    logic [31:0] cmd_addr = 0;
    logic [15:0] cmd_len = 0;
    logic        desc_valid;
    logic        desc_ready = 0;
    logic [7:0]  d_op;
    logic [31:0] d_addr;
    logic [2:0]  d_ab;
    logic [1:0]  d_al, d_dl, d_dir;
    logic [4:0]  d_dm;
    logic [15:0] d_len;
    logic        addr4, wel, err;

    int errors = 0;
    int checks = 0;
    desc_t exp_q[$];
    desc_t act;

    qspi_cmd_sequencer #(.ADDR_W(32), .LEN_W(16), .DEPTH(4), .AUTO_WREN(1)) dut (
        .clk(clk), .reset(reset), .flash_type_i(flash_type),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_id_i(cmd_id),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .desc_valid_o(desc_valid), .desc_ready_i(desc_ready),
        .desc_opcode_o(d_op), .desc_addr_o(d_addr), .desc_addr_bytes_o(d_ab),
        .desc_addr_lanes_o(d_al), .desc_dummy_o(d_dm), .desc_data_lanes_o(d_dl),
        .desc_dir_o(d_dir), .desc_len_o(d_len),
        .addr4_mode_o(addr4), .wel_o(wel), .err_o(err)
    );

    always #5 clk = ~clk;

    assign act = {d_op, d_addr, d_ab, d_al, d_dm, d_dl, d_dir, d_len};

    always @(negedge clk) begin
        if (reset && desc_valid && desc_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL desc_unexpected: got %h, none expected", act);
            end else begin
                if (act !== exp_q[0]) begin
                    errors++;
                    $display("FAIL desc: got %h, expected %h", act, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic desc_t mk(input logic [7:0] op, input logic [31:0] a,
                                 input logic [2:0] ab, input logic [1:0] al,
                                 input logic [4:0] dm, input logic [1:0] dl,
                                 input logic [1:0] dir, input logic [15:0] len);
        return {op, a, ab, al, dm, dl, dir, len};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the accept edge (E0+1).
    task automatic issue(input logic [1:0] ft, input logic [4:0] id,
                         input logic [31:0] a, input logic [15:0] l);
        int n = 0;
        while (!cmd_ready && n < 60) begin
            tick(1);
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL accept_timeout: cmd_ready=%0b for id %0d, expected 1", cmd_ready, id);
        end else begin
            flash_type = ft; cmd_id = id; cmd_addr = a; cmd_len = l; cmd_valid = 1;
            tick(1);
            cmd_valid = 0;
        end
    endtask

    task automatic drain();
        int n = 0;
        desc_ready = 1;
        while ((exp_q.size() != 0 || desc_valid) && n < 200) begin
            tick(1);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    localparam desc_t WREN = {8'h06, 32'h0, 3'd0, 2'd0, 5'd0, 2'd0, 2'd0, 16'h0};

    initial begin
        // reset state
        #2;
        check("rst_ready", cmd_ready, 0);
        check("rst_valid", desc_valid, 0);
        check("rst_fields", {d_op, d_ab, d_dm, d_len}, 0);
        check("rst_wel_addr4_err", {wel, addr4, err}, 0);
        tick(2);
        reset = 1;
        #1;
        check("rel_ready", cmd_ready, 1);

        // Winbond QIOR, latency two edges
        exp_q.push_back(mk(8'hEB, 32'h123456, 3'd3, 2'd2, 5'd6, 2'd2, 2'b01, 16'd16));
        issue(2'b01, 5'd5, 32'h123456, 16'd16);
        check("lat_e0", desc_valid, 0);
        tick(1);
        check("lat_e1", desc_valid, 0);
        tick(1);
        check("lat_e2", desc_valid, 1);
        drain();

        // Micron PP auto-WREN, wel 1 then 0
        exp_q.push_back(WREN);
        exp_q.push_back(mk(8'h02, 32'h000200, 3'd3, 2'd0, 5'd0, 2'd0, 2'b10, 16'd32));
        issue(2'b00, 5'd6, 32'h000200, 16'd32);
        tick(2);
        check("wel_after_wren", wel, 1);
        tick(1);
        check("wel_after_pp", wel, 0);
        drain();
        // explicit WREN first: no auto insertion
        exp_q.push_back(WREN);
        issue(2'b00, 5'd13, 32'h0, 16'd5);
        tick(2);
        check("wel_explicit", wel, 1);
        exp_q.push_back(mk(8'h02, 32'h000300, 3'd3, 2'd0, 5'd0, 2'd0, 2'b10, 16'd8));
        issue(2'b00, 5'd6, 32'h000300, 16'd8);
        drain();
        check("wel_after_pp2", wel, 0);

        // 4-byte address mode on Infineon
        exp_q.push_back(mk(8'hB7, 32'h0, 3'd0, 2'd0, 5'd0, 2'd0, 2'b00, 16'd0));
        issue(2'b10, 5'd17, 32'h0, 16'd0);
        tick(2);
        check("addr4_set", addr4, 1);
        exp_q.push_back(mk(8'h03, 32'h01000000, 3'd4, 2'd0, 5'd0, 2'd0, 2'b01, 16'd4));
        issue(2'b10, 5'd0, 32'h01000000, 16'd4);
        exp_q.push_back(mk(8'h99, 32'h0, 3'd0, 2'd0, 5'd0, 2'd0, 2'b00, 16'd0));
        issue(2'b10, 5'd16, 32'h0, 16'd0);
        tick(2);
        check("addr4_rst", addr4, 0);
        drain();

        // illegal requests, with wel=1 and addr4=1 to show nothing changes
        exp_q.push_back(WREN);
        issue(2'b01, 5'd13, 32'h0, 16'd0);
        exp_q.push_back(mk(8'hB7, 32'h0, 3'd0, 2'd0, 5'd0, 2'd0, 2'b00, 16'd0));
        issue(2'b01, 5'd17, 32'h0, 16'd0);
        drain();
        issue(2'b01, 5'd25, 32'h55, 16'd1);
        check("err_id_e0", err, 0);
        tick(1);
        check("err_id_e1", err, 1);
        tick(1);
        check("err_id_e2", err, 0);
        issue(2'b11, 5'd0, 32'h66, 16'd1);
        tick(1);
        check("err_type_e1", err, 1);
        tick(1);
        check("err_type_e2", err, 0);
        tick(3);
        check("err_no_desc", desc_valid, 0);
        check("err_state_kept", {wel, addr4}, 2'b11);
        exp_q.push_back(mk(8'hE9, 32'h0, 3'd0, 2'd0, 5'd0, 2'd0, 2'b00, 16'd0));
        issue(2'b01, 5'd18, 32'h0, 16'd0);
        drain();

        // fill to backpressure, then concurrent push/pop through wrap
        desc_ready = 0;
        exp_q.push_back(mk(8'h05, 32'h0, 3'd0, 2'd0, 5'd0, 2'd0, 2'b01, 16'd2));
        issue(2'b01, 5'd11, 32'h777, 16'd2);
        exp_q.push_back(mk(8'h9F, 32'h0, 3'd0, 2'd0, 5'd0, 2'd0, 2'b01, 16'd3));
        issue(2'b01, 5'd14, 32'h0, 16'd3);
        tick(2);
        check("ready_at_2", cmd_ready, 1);
        exp_q.push_back(mk(8'h0B, 32'h000ABC, 3'd3, 2'd0, 5'd8, 2'd0, 2'b01, 16'd8));
        issue(2'b01, 5'd1, 32'h000ABC, 16'd8);
        tick(2);
        check("ready_at_3", cmd_ready, 0);
        tick(3);
        check("ready_held", cmd_ready, 0);
        desc_ready = 1;
        exp_q.push_back(mk(8'h3B, 32'h10, 3'd3, 2'd0, 5'd8, 2'd1, 2'b01, 16'd4));
        issue(2'b00, 5'd2, 32'h10, 16'd4);
        exp_q.push_back(mk(8'h6B, 32'h20, 3'd3, 2'd0, 5'd8, 2'd2, 2'b01, 16'd5));
        issue(2'b10, 5'd3, 32'h20, 16'd5);
        exp_q.push_back(mk(8'hBB, 32'h30, 3'd3, 2'd1, 5'd4, 2'd1, 2'b01, 16'd6));
        issue(2'b00, 5'd4, 32'h30, 16'd6);
        exp_q.push_back(mk(8'hEB, 32'h40, 3'd3, 2'd2, 5'd10, 2'd2, 2'b01, 16'd7));
        issue(2'b00, 5'd5, 32'h40, 16'd7);
        exp_q.push_back(mk(8'h38, 32'h50, 3'd3, 2'd0, 5'd0, 2'd2, 2'b10, 16'd9));
        issue(2'b00, 5'd7, 32'h50, 16'd9);
        exp_q.push_back(WREN);
        exp_q.push_back(mk(8'h60, 32'h0, 3'd0, 2'd0, 5'd0, 2'd0, 2'b00, 16'd0));
        issue(2'b10, 5'd10, 32'h9999, 16'd12);
        drain();

        // reset while in PUSH_WREN
        exp_q.push_back(mk(8'hB7, 32'h0, 3'd0, 2'd0, 5'd0, 2'd0, 2'b00, 16'd0));
        issue(2'b01, 5'd17, 32'h0, 16'd0);
        drain();
        desc_ready = 0;
        issue(2'b01, 5'd8, 32'h1000, 16'd0);
        tick(1);
        reset = 0;
        #1;
        check("mid_rst_ready", cmd_ready, 0);
        check("mid_rst_valid", desc_valid, 0);
        check("mid_rst_state", {wel, addr4, err}, 0);
        tick(2);
        reset = 1;
        #1;
        check("mid_rel_ready", cmd_ready, 1);
        tick(3);
        check("mid_rel_empty", desc_valid, 0);
        exp_q.push_back(WREN);
        exp_q.push_back(mk(8'h01, 32'h0, 3'd0, 2'd0, 5'd0, 2'd0, 2'b10, 16'd1));
        issue(2'b01, 5'd12, 32'h0, 16'd1);
        drain();
        check("final_addr4", addr4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
